// File: rtl/ram_port_arbiter.sv
// Single-port RAM arbiter: the CPU sequencer owns the RAM by default; panel (PNL)
// and data-break (BRK) masters get one-word accesses, round-robin, with the CPU parked.
module ram_port_arbiter #(
    parameter int AW = 12,
    parameter int DW = 12
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          cpu_running,
    input  logic          cpu_boundary,
    output logic          cpu_hold,
    input  logic          cpu_oe,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    input  logic          pnl_req,
    input  logic          pnl_we,
    input  logic [AW-1:0] pnl_addr,
    input  logic [DW-1:0] pnl_wdata,
    output logic          pnl_ack,
    output logic [DW-1:0] pnl_rdata,
    input  logic          brk_req,
    input  logic          brk_we,
    input  logic [AW-1:0] brk_addr,
    input  logic [DW-1:0] brk_wdata,
    output logic          brk_ack,
    output logic [DW-1:0] brk_rdata,
    output logic          ram_oe,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          collision
);

    typedef enum logic [1:0] {ST_CPU, ST_HOLD, ST_ACC, ST_CAP} state_t;

    state_t        state;
    logic          rr_ptr;     // 0 = PNL preferred, 1 = BRK preferred
    logic          lat_sel;    // 0 = PNL, 1 = BRK
    logic          lat_we;
    logic [AW-1:0] lat_addr;
    logic [DW-1:0] lat_wdata;

    logic          pnl_pend, brk_pend, any_pend, other_pend, win_sel;
    logic          cand_sel, cand_we, take;
    logic [AW-1:0] cand_addr;
    logic [DW-1:0] cand_wdata;

    // A request still high during its own ack cycle is the old one, not a new one.
    assign pnl_pend   = pnl_req & ~pnl_ack;
    assign brk_pend   = brk_req & ~brk_ack;
    assign any_pend   = pnl_pend | brk_pend;
    assign win_sel    = (pnl_pend & brk_pend) ? rr_ptr : brk_pend;
    assign other_pend = lat_sel ? pnl_pend : brk_pend;

    assign cand_sel   = (state == ST_CAP) ? ~lat_sel : win_sel;
    assign cand_we    = cand_sel ? brk_we    : pnl_we;
    assign cand_addr  = cand_sel ? brk_addr  : pnl_addr;
    assign cand_wdata = cand_sel ? brk_wdata : pnl_wdata;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
        take = 1'b0;
        unique case (state)
            ST_CPU:  take = any_pend & ~cpu_running;
            ST_HOLD: take = any_pend & (cpu_boundary | ~cpu_running);
            ST_CAP:  take = other_pend;
            default: take = 1'b0;
        endcase
    end

    always_comb begin
        ram_oe    = cpu_oe;
        ram_we    = cpu_we;
        ram_addr  = cpu_addr;
        ram_wdata = cpu_wdata;
        if (state == ST_ACC) begin
            ram_oe    = ~lat_we;
            ram_we    = lat_we;
            ram_addr  = lat_addr;
            ram_wdata = lat_wdata;
        end else if (state == ST_CAP) begin
            ram_oe    = 1'b0;
            ram_we    = 1'b0;
            ram_addr  = lat_addr;
            ram_wdata = lat_wdata;
        end
    end

    assign cpu_rdata = ram_rdata;

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= ST_CPU;
            cpu_hold  <= 1'b0;
            pnl_ack   <= 1'b0;
            brk_ack   <= 1'b0;
            pnl_rdata <= '0;
            brk_rdata <= '0;
            collision <= 1'b0;
            rr_ptr    <= 1'b0;
            lat_sel   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            pnl_ack <= 1'b0;
            brk_ack <= 1'b0;

            if ((state == ST_ACC || state == ST_CAP) && (cpu_oe || cpu_we))
                collision <= 1'b1;

            if (take) begin
                lat_sel   <= cand_sel;
                lat_we    <= cand_we;
                lat_addr  <= cand_addr;
                lat_wdata <= cand_wdata;
            end

            unique case (state)
                ST_CPU: begin
                    if (take) begin
                        state <= ST_ACC;
                    end else if (any_pend) begin
                        state    <= ST_HOLD;
                        cpu_hold <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!any_pend) begin
                        state    <= ST_CPU;
                        cpu_hold <= 1'b0;
                    end else if (take) begin
                        state <= ST_ACC;
                    end
                end
                ST_ACC: state <= ST_CAP;
                ST_CAP: begin
                    if (lat_sel) begin
                        brk_ack <= 1'b1;
                        if (!lat_we) brk_rdata <= ram_rdata;
                    end else begin
                        pnl_ack <= 1'b1;
                        if (!lat_we) pnl_rdata <= ram_rdata;
                    end
                    rr_ptr <= ~rr_ptr;
                    if (take) begin
                        state <= ST_ACC;
                    end else begin
                        state    <= ST_CPU;
                        cpu_hold <= 1'b0;
                    end
                end
                default: state <= ST_CPU;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a simple synchronous-read RAM model.
module tb_ram_port_arbiter;

    localparam int AW = 12;
    localparam int DW = 12;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          cpu_running, cpu_boundary, cpu_hold;
    logic          cpu_oe, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          pnl_req, pnl_we, pnl_ack;
    logic [AW-1:0] pnl_addr;
    logic [DW-1:0] pnl_wdata, pnl_rdata;
    logic          brk_req, brk_we, brk_ack;
    logic [AW-1:0] brk_addr;
    logic [DW-1:0] brk_wdata, brk_rdata;
    logic          ram_oe, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          collision;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    always @(posedge CLK) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        if (ram_oe) ram_rdata <= mem[ram_addr];
    end

    ram_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .CLK(CLK), .RESET(RESET),
        .cpu_running(cpu_running), .cpu_boundary(cpu_boundary), .cpu_hold(cpu_hold),
        .cpu_oe(cpu_oe), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .pnl_req(pnl_req), .pnl_we(pnl_we), .pnl_addr(pnl_addr),
        .pnl_wdata(pnl_wdata), .pnl_ack(pnl_ack), .pnl_rdata(pnl_rdata),
        .brk_req(brk_req), .brk_we(brk_we), .brk_addr(brk_addr),
        .brk_wdata(brk_wdata), .brk_ack(brk_ack), .brk_rdata(brk_rdata),
        .ram_oe(ram_oe), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .collision(collision)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1; cpu_running = 1'b0; cpu_boundary = 1'b0;
        cpu_oe = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        pnl_req = 1'b0; pnl_we = 1'b0; pnl_addr = '0; pnl_wdata = '0;
        brk_req = 1'b0; brk_we = 1'b0; brk_addr = '0; brk_wdata = '0;
        ram_rdata = '0;
        tick(); tick();
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL reset_hold: got %b want 0", cpu_hold); end
        total++; if ({pnl_ack, brk_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks: got %b want 00", {pnl_ack, brk_ack}); end
        total++; if (pnl_rdata !== 12'o0000) begin bad++; $display("FAIL reset_pnl_rdata: got %o want 0000", pnl_rdata); end
        total++; if (brk_rdata !== 12'o0000) begin bad++; $display("FAIL reset_brk_rdata: got %o want 0000", brk_rdata); end
        total++; if (collision !== 1'b0) begin bad++; $display("FAIL reset_collision: got %b want 0", collision); end
        RESET = 1'b0;
        // CPU write passthrough, also preloads the word examined later
        cpu_we = 1'b1; cpu_addr = 12'o0200; cpu_wdata = 12'o7402;
        #1;
        total++; if ({ram_oe, ram_we} !== 2'b01) begin bad++; $display("FAIL cpu_pass_we: got %b want 01", {ram_oe, ram_we}); end
        total++; if (ram_addr !== 12'o0200 || ram_wdata !== 12'o7402) begin bad++; $display("FAIL cpu_pass_wr: got %o/%o want 0200/7402", ram_addr, ram_wdata); end
        tick();
        cpu_we = 1'b0; cpu_oe = 1'b1;
        tick();
        cpu_oe = 1'b0;
        #1;
        total++; if (ram_oe !== 1'b0) begin bad++; $display("FAIL cpu_pass_oe: got %b want 0", ram_oe); end
        total++; if (cpu_rdata !== 12'o7402) begin bad++; $display("FAIL cpu_rdata: got %o want 7402", cpu_rdata); end
    endtask

    task automatic test_halted_read();
        cpu_running = 1'b0;
        pnl_req = 1'b1; pnl_we = 1'b0; pnl_addr = 12'o0200;
        tick();
        total++; if (ram_oe !== 1'b1 || ram_we !== 1'b0 || ram_addr !== 12'o0200) begin bad++; $display("FAIL halted_acc: got oe=%b we=%b addr=%o want 1 0 0200", ram_oe, ram_we, ram_addr); end
        total++; if (cpu_hold !== 1'b0 || pnl_ack !== 1'b0) begin bad++; $display("FAIL halted_acc_flags: got hold=%b ack=%b want 0 0", cpu_hold, pnl_ack); end
        tick();
        total++; if (ram_oe !== 1'b0 || pnl_ack !== 1'b0) begin bad++; $display("FAIL halted_cap: got oe=%b ack=%b want 0 0", ram_oe, pnl_ack); end
        tick();
        total++; if (pnl_ack !== 1'b1 || brk_ack !== 1'b0) begin bad++; $display("FAIL halted_ack: got pnl=%b brk=%b want 1 0", pnl_ack, brk_ack); end
        total++; if (pnl_rdata !== 12'o7402) begin bad++; $display("FAIL halted_rdata: got %o want 7402", pnl_rdata); end
        total++; if (cpu_hold !== 1'b0) begin bad++; $display("FAIL halted_hold: got %b want 0", cpu_hold); end
        pnl_req = 1'b0;
        tick();
        total++; if (pnl_ack !== 1'b0 || pnl_rdata !== 12'o7402 || ram_oe !== 1'b0) begin bad++; $display("FAIL halted_after: got ack=%b rdata=%o oe=%b want 0 7402 0", pnl_ack, pnl_rdata, ram_oe); end
    endtask

    task automatic test_running_write();
        cpu_running = 1'b1; cpu_boundary = 1'b0;
        brk_req = 1'b1; brk_we = 1'b1; brk_addr = 12'o0017; brk_wdata = 12'o1234;
        tick();
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL run_hold_rise: got %b want 1", cpu_hold); end
        cpu_oe = 1'b1; cpu_addr = 12'o0555;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (ram_we !== 1'b0 || ram_oe !== 1'b1 || ram_addr !== 12'o0555 || brk_ack !== 1'b0) begin bad++; $display("FAIL run_wait%0d: got we=%b oe=%b addr=%o ack=%b want 0 1 0555 0", i, ram_we, ram_oe, ram_addr, brk_ack); end
        end
        cpu_oe = 1'b0; cpu_boundary = 1'b1;
        tick();
        cpu_boundary = 1'b0;
        total++; if (ram_we !== 1'b1 || ram_addr !== 12'o0017 || ram_wdata !== 12'o1234) begin bad++; $display("FAIL run_acc: got we=%b addr=%o data=%o want 1 0017 1234", ram_we, ram_addr, ram_wdata); end
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL run_acc_hold: got %b want 1", cpu_hold); end
        tick();
        tick();
        total++; if (brk_ack !== 1'b1 || cpu_hold !== 1'b0) begin bad++; $display("FAIL run_ack: got ack=%b hold=%b want 1 0", brk_ack, cpu_hold); end
        total++; if (brk_rdata !== 12'o0000) begin bad++; $display("FAIL run_rdata_kept: got %o want 0000", brk_rdata); end
        brk_req = 1'b0;
        tick();
        total++; if (mem[12'o0017] !== 12'o1234 || brk_ack !== 1'b0) begin bad++; $display("FAIL run_mem: got %o ack=%b want 1234 0", mem[12'o0017], brk_ack); end
    endtask

    task automatic test_back_to_back();
        cpu_running = 1'b1; cpu_boundary = 1'b1;
        pnl_req = 1'b1; pnl_we = 1'b0; pnl_addr = 12'o0200;
        brk_req = 1'b1; brk_we = 1'b0; brk_addr = 12'o0017;
        tick();
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL b2b_hold: got %b want 1", cpu_hold); end
        tick();
        total++; if (ram_oe !== 1'b1 || ram_addr !== 12'o0200) begin bad++; $display("FAIL b2b_first: got oe=%b addr=%o want 1 0200", ram_oe, ram_addr); end
        tick();
        tick();
        total++; if (pnl_ack !== 1'b1 || brk_ack !== 1'b0 || pnl_rdata !== 12'o7402) begin bad++; $display("FAIL b2b_pnl_ack: got p=%b b=%b rd=%o want 1 0 7402", pnl_ack, brk_ack, pnl_rdata); end
        total++; if (ram_oe !== 1'b1 || ram_addr !== 12'o0017 || cpu_hold !== 1'b1) begin bad++; $display("FAIL b2b_second: got oe=%b addr=%o hold=%b want 1 0017 1", ram_oe, ram_addr, cpu_hold); end
        pnl_req = 1'b0;
        tick();
        total++; if (cpu_hold !== 1'b1 || pnl_ack !== 1'b0) begin bad++; $display("FAIL b2b_cap: got hold=%b ack=%b want 1 0", cpu_hold, pnl_ack); end
        tick();
        total++; if (brk_ack !== 1'b1 || brk_rdata !== 12'o1234 || cpu_hold !== 1'b0) begin bad++; $display("FAIL b2b_brk_ack: got ack=%b rd=%o hold=%b want 1 1234 0", brk_ack, brk_rdata, cpu_hold); end
        brk_req = 1'b0; cpu_boundary = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        cpu_running = 1'b0;
        pnl_req = 1'b1; pnl_we = 1'b1; pnl_addr = 12'o0300; pnl_wdata = 12'o5555;
        tick();
        cpu_we = 1'b1; cpu_addr = 12'o0300; cpu_wdata = 12'o7777;
        #1;
        total++; if (ram_we !== 1'b1 || ram_wdata !== 12'o5555) begin bad++; $display("FAIL coll_blocked: got we=%b data=%o want 1 5555", ram_we, ram_wdata); end
        tick();
        cpu_we = 1'b0;
        total++; if (collision !== 1'b1) begin bad++; $display("FAIL coll_set: got %b want 1", collision); end
        tick();
        pnl_req = 1'b0;
        tick(); tick();
        total++; if (mem[12'o0300] !== 12'o5555) begin bad++; $display("FAIL coll_mem: got %o want 5555", mem[12'o0300]); end
        total++; if (collision !== 1'b1) begin bad++; $display("FAIL coll_sticky: got %b want 1", collision); end
        RESET = 1'b1;
        #1;
        total++; if (collision !== 1'b0) begin bad++; $display("FAIL coll_clear: got %b want 0", collision); end
        tick();
        RESET = 1'b0;
    endtask

    task automatic test_reset_midaccess();
        cpu_running = 1'b1; cpu_boundary = 1'b0;
        brk_req = 1'b1; brk_we = 1'b0; brk_addr = 12'o0017;
        tick();
        total++; if (cpu_hold !== 1'b1) begin bad++; $display("FAIL rst_hold_pre: got %b want 1", cpu_hold); end
        RESET = 1'b1;
        #1;
        total++; if (cpu_hold !== 1'b0 || brk_ack !== 1'b0 || brk_rdata !== 12'o0000) begin bad++; $display("FAIL rst_in_hold: got hold=%b ack=%b rd=%o want 0 0 0000", cpu_hold, brk_ack, brk_rdata); end
        brk_req = 1'b0;
        tick();
        RESET = 1'b0;
        cpu_running = 1'b0;
        pnl_req = 1'b1; pnl_we = 1'b0; pnl_addr = 12'o0200;
        tick();
        total++; if (ram_oe !== 1'b1 || ram_addr !== 12'o0200) begin bad++; $display("FAIL rst_acc_pre: got oe=%b addr=%o want 1 0200", ram_oe, ram_addr); end
        RESET = 1'b1;
        #1;
        total++; if (ram_oe !== 1'b0 || pnl_ack !== 1'b0 || pnl_rdata !== 12'o0000 || cpu_hold !== 1'b0) begin bad++; $display("FAIL rst_in_acc: got oe=%b ack=%b rd=%o hold=%b want 0 0 0000 0", ram_oe, pnl_ack, pnl_rdata, cpu_hold); end
        pnl_req = 1'b0;
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (pnl_ack !== 1'b0 || pnl_rdata !== 12'o0000) begin bad++; $display("FAIL rst_no_ack%0d: got ack=%b rd=%o want 0 0000", i, pnl_ack, pnl_rdata); end
        end
    endtask

    task automatic test_rr_after_reset();
        cpu_running = 1'b0;
        pnl_req = 1'b1; pnl_we = 1'b0; pnl_addr = 12'o0200;
        brk_req = 1'b1; brk_we = 1'b0; brk_addr = 12'o0017;
        tick();
        total++; if (ram_addr !== 12'o0200) begin bad++; $display("FAIL rr_reset_first: got %o want 0200", ram_addr); end
        tick(); tick();
        pnl_req = 1'b0;
        tick(); tick();
        total++; if (brk_ack !== 1'b1 || brk_rdata !== 12'o1234) begin bad++; $display("FAIL rr_reset_second: got ack=%b rd=%o want 1 1234", brk_ack, brk_rdata); end
        brk_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_halted_read();
        test_running_write();
        test_back_to_back();
        test_collision();
        test_reset_midaccess();
        test_rr_after_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
